sqrt_job_sequencer: RTL and testbench
=====================================

Name: sqrt_job_sequencer

Overview:
Upstream feeder for the iterative square-root core. It accepts radicands on a valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the core using the core's start/busy/done handshake, then captures each root into an output register and presents it on a valid/ready result stream. It sits between the CPU/bus-side producer and the sqrt core, so the producer never has to poll the core.

Parameters:
DEPTH, 4, input FIFO entries; power of 2, minimum 2.
TAG_W, 4, tag width; used only when SQRT_SEQ_TAG_EN is defined.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  radicand offered.
in_ready  out  1  FIFO not full.
in_data  in  32  radicand.
out_valid  out  1  result register holds an undrained root.
out_ready  in  1  consumer accepts result.
out_data  out  32  root; bits 31:16 always 0.
core_start  out  1  one-cycle start pulse to the core.
core_radicand  out  32  radicand for the core; valid while core_start=1.
core_busy  in  1  core computing.
core_done  in  1  core one-cycle completion pulse.
core_root  in  32  core result; stable from the core_done cycle until the next start.
seq_busy  out  1  FSM not IDLE, or FIFO not empty.
pending  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous) clears all state:
  - FSM goes to IDLE; FIFO is emptied (pointers and count = 0).
  - Output values: out_valid=0, out_data=0, core_start=0, core_radicand=0, seq_busy=0, pending=0, in_ready=1.
  - The core shares rst, so a job in flight is abandoned and no result is produced for it.
- Input FIFO:
  - Push when in_valid && in_ready. in_ready = !full, taken from registered state.
  - When full, an input is not accepted even if a pop happens in the same cycle.
  - Push and pop in the same cycle is legal when the FIFO is neither empty nor full; count is unchanged.
  - No bypass path: a word pushed into an empty FIFO can be popped at the earliest on the next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, STALL.
  - IDLE: if the FIFO is not empty, go to ISSUE.
  - ISSUE: core_start=1 for exactly one cycle, core_radicand=FIFO head, pop the FIFO; go to WAIT. core_start is only ever asserted here. The core is guaranteed idle in this state.
  - WAIT: hold until core_done=1.
    - On done with the result slot free (!out_valid, or out_ready in the same cycle): load out_data=core_root and set out_valid=1. Then go to ISSUE if the FIFO is not empty, else IDLE.
    - On done with the slot occupied and not draining: go to STALL.
  - STALL: when the slot frees, load out_data from core_root (still stable, since no new start has been issued) and set out_valid=1. Then go to ISSUE or IDLE using the same rule as WAIT.
- core_done outside WAIT is ignored. core_busy is used only as a guard: ISSUE is never entered while core_busy=1.
- Output handshake:
  - out_valid is cleared on out_valid && out_ready, unless a new load happens in the same cycle, in which case out_valid stays 1 with the new data.
  - out_data is held while out_valid=1 && !out_ready.
- Latency with no backpressure:
  - Input accept edge E0 to out_valid=1 after edge E19 (19 cycles).
  - Sustained back-to-back throughput is 1 job per 18 cycles (WAIT goes directly to ISSUE).
- seq_busy = (state != IDLE) || (count != 0).

Optional Feature:
SQRT_SEQ_TAG_EN
- Defined:
  - Adds ports in_tag (in, TAG_W) and out_tag (out, TAG_W).
  - The tag is stored in the FIFO alongside the radicand and held in an in-flight register from ISSUE onward.
  - out_tag loads together with out_data, so results can be matched to requests.
  - out_tag resets to 0.
- Undefined: no tag ports and no tag storage; behaviour is otherwise identical.

Test Plan:
- Single job, out_ready=1: in_data=144 → out_data=12, out_valid=1 exactly 19 cycles after accept, core_start pulses once.
- Boundary values: 0→0, 1→1, 2→1, 0xFFFFFFFF→0x0000FFFF, 0x40000000→0x00008000; results in order.
- Fill: hold in_valid=1 with 6 radicands (DEPTH=4) → in_ready drops after 4 are buffered and the first pop reopens a slot. All 6 roots arrive in order, 18 cycles apart, pending never exceeds 4.
- Backpressure: out_ready=0 for 60 cycles with 3 jobs queued → first root held stable, FSM enters STALL on the second done, no third core_start until out_ready=1. Afterwards all 3 roots are delivered uncorrupted.
- Reset mid-job: assert rst 8 cycles after core_start → out_valid=0, pending=0, in_ready=1 immediately (asynchronously). No result ever emerges for the aborted job; a new job of 49 gives 7.
- SQRT_SEQ_TAG_EN defined: tags 3,5,9 with radicands 9,25,81 → (out_data,out_tag) = (3,3),(5,5),(9,9).

Source files
------------

// File: rtl/sqrt_job_sequencer.sv
// rtl/sqrt_job_sequencer.sv - radicand FIFO and job sequencer in front of the iterative sqrt core
// Optional tag passthrough enabled by defining SQRT_SEQ_TAG_EN.
module sqrt_job_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
`ifdef SQRT_SEQ_TAG_EN
   input  logic [TAG_W-1:0]       in_tag,
   output logic [TAG_W-1:0]       out_tag,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic                   core_start,
   output logic [31:0]            core_radicand,
   input  logic                   core_busy,
   input  logic                   core_done,
   input  logic [31:0]            core_root,
   output logic                   seq_busy,
   output logic [$clog2(DEPTH):0] pending
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STALL} state_t;

   state_t        state_q, state_d;
   logic [31:0]   mem_data [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic          slot_free, issue_ok, load;
   logic [15:0]   root_q;
   logic          unused_root;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full;

   assign slot_free = !out_valid || out_ready;
   assign issue_ok  = !empty && !core_busy;

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_data[wr_ptr] <= in_data;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (issue_ok) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               if (slot_free) state_d = issue_ok ? S_ISSUE : S_IDLE;
               else           state_d = S_STALL;
            end
         end
         S_STALL: if (slot_free) state_d = issue_ok ? S_ISSUE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_start = 1'b0;
      pop        = 1'b0;
      load       = 1'b0;
      case (state_q)
         S_ISSUE: begin
            core_start = 1'b1;
            pop        = 1'b1;
         end
         S_WAIT:  load = core_done && slot_free;
         // core_root stays stable in STALL because no new start has gone out
         S_STALL: load = slot_free;
         default: ;
      endcase
   end

   assign core_radicand = core_start ? mem_data[rd_ptr] : 32'd0;

   // ---------------------------------------------------------------- result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         root_q    <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         root_q    <= core_root[15:0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_data    = {16'd0, root_q};
   assign unused_root = ^core_root[31:16];

`ifdef SQRT_SEQ_TAG_EN
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic [TAG_W-1:0] flight_tag;

   always_ff @(posedge clk) begin
      if (push) mem_tag[wr_ptr] <= in_tag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flight_tag <= '0;
         out_tag    <= '0;
      end else begin
         if (pop)  flight_tag <= mem_tag[rd_ptr];
         if (load) out_tag    <= flight_tag;
      end
   end
`else
   logic [TAG_W-1:0] unused_tag;
   assign unused_tag = '0;
`endif

   assign seq_busy = (state_q != S_IDLE) || !empty;
   assign pending  = count;

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// tb/tb_sqrt_job_sequencer.sv - scoreboard bench for sqrt_job_sequencer with a 16-cycle core model
module tb_sqrt_job_sequencer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_data;
   logic             core_start;
   logic [31:0]      core_radicand;
   logic             core_busy;
   logic             core_done;
   logic [31:0]      core_root;
   logic             seq_busy;
   logic [2:0]       pending;
`ifdef SQRT_SEQ_TAG_EN
   logic [TAG_W-1:0] in_tag = '0;
   logic [TAG_W-1:0] out_tag;
`endif

   sqrt_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
`ifdef SQRT_SEQ_TAG_EN
      .in_tag        (in_tag),
      .out_tag       (out_tag),
`endif
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .core_start    (core_start),
      .core_radicand (core_radicand),
      .core_busy     (core_busy),
      .core_done     (core_done),
      .core_root     (core_root),
      .seq_busy      (seq_busy),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] isqrt(input logic [31:0] v);
      logic [31:0] r;
      longint unsigned t;
      r = 0;
      for (int b = 15; b >= 0; b--) begin
         t = longint'(r | (32'd1 << b));
         if (t * t <= longint'(v)) r = r | (32'd1 << b);
      end
      return r;
   endfunction

   // sqrt core model: start sampled at edge S, done pulse in the cycle after edge S+16
   logic [4:0]  core_cnt;
   logic [31:0] core_rad;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_busy <= 1'b0;
         core_done <= 1'b0;
         core_cnt  <= '0;
         core_rad  <= '0;
         core_root <= '0;
      end else begin
         core_done <= 1'b0;
         if (core_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 5'd15;
            core_rad  <= core_radicand;
         end else if (core_busy) begin
            if (core_cnt == 0) begin
               core_busy <= 1'b0;
               core_done <= 1'b1;
               core_root <= isqrt(core_rad);
            end else begin
               core_cnt <= core_cnt - 5'd1;
            end
         end
      end
   end

   logic [31:0]      exp_q[$];
   logic [TAG_W-1:0] exp_tag_q[$];
   int               hs_t[$];
   int               cyc = 0;
   int               n_start = 0;
   int               t_start = 0;
   int               max_pend = 0;
   bit               saw_full = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (core_start) begin
         n_start++;
         t_start = cyc;
      end
      if (int'(pending) > max_pend) max_pend = int'(pending);
      if (out_valid && out_ready) begin
         hs_t.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_out", exp_q.size(), 1);
         end else begin
            chk("result", out_data, exp_q.pop_front());
`ifdef SQRT_SEQ_TAG_EN
            chk("result_tag", out_tag, exp_tag_q.pop_front());
`endif
         end
      end
   end

   task automatic push_job(input logic [31:0] d, input logic [TAG_W-1:0] t);
      bit acc;
      int k;
      in_valid = 1'b1;
      in_data  = d;
`ifdef SQRT_SEQ_TAG_EN
      in_tag   = t;
`endif
      acc = 0;
      k   = 0;
      while (!acc && k < 200) begin
         acc = in_ready;
         if (!in_ready && pending == 3'(DEPTH)) saw_full = 1;
         @(posedge clk);
         #1;
         k++;
      end
      if (!acc) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || seq_busy) && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_timeout", k < limit, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [31:0] bnd_in  [5] = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h4000_0000};
   logic [31:0] bnd_exp [5] = '{32'd0, 32'd1, 32'd1, 32'h0000_FFFF, 32'h0000_8000};

   initial begin
      int s0, k, changes;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_radicand", core_radicand, 0);
      chk("rst_seq_busy", seq_busy, 0);
      chk("rst_pending", pending, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single job latency
      s0 = n_start;
      exp_q.push_back(32'd12);
      exp_tag_q.push_back('0);
      push_job(32'd144, '0);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("single_latency", k, 19);
      wait_drain(200);
      chk("single_starts", n_start - s0, 1);

      // boundary radicands, back to back
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(bnd_exp[i]);
         exp_tag_q.push_back('0);
         push_job(bnd_in[i], '0);
      end
      in_valid = 1'b0;
      wait_drain(500);

      // fill past DEPTH with valid held
      hs_t.delete();
      max_pend = 0;
      saw_full = 0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(32'(1000 + i));
         exp_tag_q.push_back('0);
         push_job(32'((1000 + i) * (1000 + i)), '0);
      end
      in_valid = 1'b0;
      wait_drain(500);
      chk("fill_saw_full", saw_full, 1);
      chk("fill_max_pending", max_pend, DEPTH);
      chk("fill_results", hs_t.size(), 6);
      for (int i = 0; i + 1 < hs_t.size(); i++)
         chk("fill_gap", hs_t[i+1] - hs_t[i], 18);

      // backpressure: result held, core not restarted past the stall
      out_ready = 1'b0;
      s0 = n_start;
      exp_q.push_back(32'd20);  exp_tag_q.push_back('0);
      push_job(32'd400, '0);
      exp_q.push_back(32'd30);  exp_tag_q.push_back('0);
      push_job(32'd900, '0);
      exp_q.push_back(32'd40);  exp_tag_q.push_back('0);
      push_job(32'd1600, '0);
      in_valid = 1'b0;
      changes = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (out_valid && out_data !== 32'd20) changes++;
      end
      chk("bp_hold_changes", changes, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 20);
      chk("bp_starts", n_start - s0, 2);
      chk("bp_pending", pending, 1);
      out_ready = 1'b1;
      wait_drain(500);

      // asynchronous reset while a job is in flight
      for (int i = 0; i < 5; i++) push_job(32'(2500 + i * 100), '0);
      in_valid = 1'b0;
      k = 0;
      while (cyc < t_start + 8 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("pre_rst_pending", pending, 4);
      chk("pre_rst_in_ready", in_ready, 0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_pending", pending, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_seq_busy", seq_busy, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      s0 = n_start;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_starts", n_start - s0, 0);
      chk("post_rst_out_valid", out_valid, 0);
      exp_q.push_back(32'd7);
      exp_tag_q.push_back('0);
      push_job(32'd49, '0);
      in_valid = 1'b0;
      wait_drain(200);

`ifdef SQRT_SEQ_TAG_EN
      exp_q.push_back(32'd3);  exp_tag_q.push_back(4'd3);
      push_job(32'd9, 4'd3);
      exp_q.push_back(32'd5);  exp_tag_q.push_back(4'd5);
      push_job(32'd25, 4'd5);
      exp_q.push_back(32'd9);  exp_tag_q.push_back(4'd9);
      push_job(32'd81, 4'd9);
      in_valid = 1'b0;
      wait_drain(300);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
